memory_ws: RTL
==============

// Module: memory_ws
// PURPOSE
// - Parametrised VeriRISC memory with a handshake. It replaces the fixed, zero-wait bus memory.
// - Single-port RAM on a shared tri-state data bus. It adds a 4-phase rd/wr -> ready handshake,
//   a per-access programmable wait-state count, abort on early request drop, and a conflict flag.
// - Sits between the VeriRISC controller/datapath and program/data storage.
//   Models slow memories without changing the CPU.
// PARAMETERS
// - ADDR_WIDTH  5   address bits; depth = 2**ADDR_WIDTH words
// - DATA_WIDTH  8   word width, bits
// - WS_WIDTH    4   width of wait_cfg; max wait states = 2**WS_WIDTH-1
// PORTS
// - clk       in     1           rising-edge clock
// - rst_n     in     1           asynchronous, active-low reset
// - addr      in     ADDR_WIDTH  word address; must be stable while rd or wr is asserted
// - wr        in     1           write request (level, held until ready)
// - rd        in     1           read request (level, held until ready)
// - wait_cfg  in     WS_WIDTH    wait states for this access; sampled at request accept
// - data      inout  DATA_WIDTH  shared bus; driven by this block only during a read in DONE, else Z
// - ready     out    1           access complete; high for the whole DONE state
// - err       out    1           one-cycle pulse: rd and wr asserted together in IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE, ready=0, err=0, count=0, rdata=0, data=Z.
//   - RAM contents are not cleared.
//   - Reset mid-access aborts it; a pending write is not performed.
// - FSM states: IDLE, WAIT, DONE (all outputs registered).
//   - IDLE, rd^wr=1 at edge E0: latch op, addr, write data (bus) and count<=wait_cfg; go WAIT.
//   - IDLE, rd&wr=1: no access; err=1 for one cycle; stay IDLE.
//   - WAIT, rd|wr dropped (or switched op): abort; no RAM write; go IDLE.
//   - WAIT, count!=0: count<=count-1.
//   - WAIT, count==0: perform access (write: ram[addr_q]<=wdata_q; read: rdata<=ram[addr_q]);
//     go DONE; ready<=1.
//   - DONE: hold ready=1; when rd=0 and wr=0, go IDLE with ready<=0.
//     New request is accepted only from IDLE.
// - Latency:
//   - With wait_cfg=W, the access edge is E0+W+1; ready is first visible in the cycle after it.
//   - W=0 -> ready high in the 2nd cycle after request sample.
// - Bus:
//   - data = (state==DONE && op_q==READ && rd) ? rdata : Z.
//   - Write data is captured at request accept (E0); later bus changes are ignored.
// - Widths:
//   - count is WS_WIDTH bits and decrements only while nonzero; no wrap.
//   - Address wraps naturally modulo depth.
// - Read-after-write to the same address in back-to-back handshakes returns the new data.
// STRUCTURE
// - Package memory_ws_pkg: state encoding localparams (ST_IDLE/ST_WAIT/ST_DONE),
//   op encoding (OP_READ/OP_WRITE).
// - Sub-module mem_array: plain synchronous single-port RAM (we, addr, din, dout registered),
//   params ADDR_WIDTH/DATA_WIDTH.
// - Top module: FSM, wait counter, request latches, tri-state driver, ready/err registers.
// TESTING
// - Reset: rst_n=0 mid-WAIT of write(addr=3,0xA5,W=5) -> ready=0, data=Z; later read addr 3
//   returns prior contents, not 0xA5.
// - Zero-wait: write addr 5 = 0x3C, W=0 -> ready 2nd cycle after request; read addr 5, W=0
//   -> data=0x3C while ready&&rd; Z after rd drops.
// - Wait states: read W=15 -> ready rises exactly 16 edges after request accept;
//   W=7 -> 8 edges.
// - Abort: write addr 9 = 0xFF, W=4, drop wr after 2 cycles -> ready never rises;
//   read addr 9 returns old value.
// - Conflict: rd=wr=1 in IDLE -> err pulses 1 cycle, no ready, RAM unchanged, data=Z.
// - Sweep: write addr=i, data=~i for all 32 addresses with random W; read back all
//   -> match; addr 31 and 0 checked at the boundaries.

Source files
------------

// File: rtl/memory_ws_pkg.sv
// memory_ws_pkg: shared state and operation encodings for the wait-state memory
package memory_ws_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
endpackage

// File: rtl/memory_ws_if.sv
// memory_ws_if: request/handshake signals between the CPU side and the memory
interface memory_ws_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WS_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr;
  logic                  rd;
  logic [WS_WIDTH-1:0]   wait_cfg;
  logic                  ready;
  logic                  err;
  modport master (output addr, wr, rd, wait_cfg, input ready, err);
  modport slave  (input addr, wr, rd, wait_cfg, output ready, err);
endinterface

// File: rtl/memory_ws_mem_array.sv
// mem_array: synchronous single-port RAM with registered read data
module mem_array #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/memory_ws.sv
// memory_ws: single-port RAM on a tri-state bus with rd/wr->ready handshake,
// per-access wait states, abort on request drop and rd/wr conflict flag
module memory_ws
  import memory_ws_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int WS_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  memory_ws_if.slave            bus,
  inout  wire  [DATA_WIDTH-1:0] data
);
  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, ram_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, ram_dout;
  logic [WS_WIDTH-1:0]   count_q, count_d;
  logic                  ready_q, ready_d, err_q, err_d, we, req_ok;
  // RAM follows the live address while idle so its registered output
  // already holds the target word by the time a zero-wait access fires
  assign ram_addr = (state_q == ST_IDLE) ? bus.addr : addr_q;
  mem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clk  (clk),
    .we   (we),
    .addr (ram_addr),
    .din  (wdata_q),
    .dout (ram_dout)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    we      = 1'b0;
    req_ok  = (op_q == OP_WRITE) ? (bus.wr && !bus.rd) : (bus.rd && !bus.wr);
    case (state_q)
      ST_IDLE: begin
        err_d = bus.rd & bus.wr;
        if (bus.rd ^ bus.wr) begin
          state_d = ST_WAIT;
          op_d    = bus.wr ? OP_WRITE : OP_READ;
          addr_d  = bus.addr;
          wdata_d = data;
          count_d = bus.wait_cfg;
        end
      end
      ST_WAIT: begin
        if (!req_ok) state_d = ST_IDLE;
        else if (count_q != '0) count_d = count_q - 1'b1;
        else begin
          state_d = ST_DONE;
          we      = (op_q == OP_WRITE);
          rdata_d = (op_q == OP_READ) ? ram_dout : rdata_q;
        end
      end
      ST_DONE: state_d = (!bus.rd && !bus.wr) ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign data = (state_q == ST_DONE && op_q == OP_READ && bus.rd) ? rdata_q : {DATA_WIDTH{1'bz}};
endmodule
